sram_1r1w_mask_ext: RTL and testbench



---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_1r1w_mask_ext_if.sv | 32 +++
 rtl/sram_mask_merge.sv | 24 ++
 rtl/sram_1r1w_mask_ext.sv | 123 ++++++++++++
 tb/tb_sram_1r1w_mask_ext.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the 1R1W masked SRAM primitive.
// Combinational only: no latency, no flow control.
package sram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_t;

    // Address width for a given depth; never below 1 so ports stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int mask_segs(input int width, input int gran);
        return width / gran;
    endfunction

endpackage

// File: rtl/sram_1r1w_mask_ext_if.sv
// Read/write port bundle for sram_1r1w_mask_ext; master drives requests, slave returns read data.
// No backpressure: the master must take R0_data in the cycle R0_valid is high.
interface sram_1r1w_mask_ext_if #(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 512,
    parameter int MASK_GRAN = 512
) ();
    import sram_pkg::*;

    localparam int ADDR_W    = clog2(DEPTH);
    localparam int MASK_SEGS = mask_segs(WIDTH, MASK_GRAN);

    logic [ADDR_W-1:0]    R0_addr;
    logic                 R0_en;
    logic [WIDTH-1:0]     R0_data;
    logic                 R0_valid;
    logic [ADDR_W-1:0]    W0_addr;
    logic                 W0_en;
    logic [WIDTH-1:0]     W0_data;
    logic [MASK_SEGS-1:0] W0_mask;

    modport master (
        output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
        input  R0_data, R0_valid
    );

    modport slave (
        input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
        output R0_data, R0_valid
    );

endinterface

// File: rtl/sram_mask_merge.sv
// Lane-wise merge: each lane takes new_i when its mask bit is set, else old_i.
// Purely combinational, no flow control.
module sram_mask_merge
    import sram_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int MASK_GRAN = 512
) (
    input  logic [WIDTH-1:0]                           old_i,
    input  logic [WIDTH-1:0]                           new_i,
    input  logic [mask_segs(WIDTH, MASK_GRAN)-1:0]     mask_i,
    output logic [WIDTH-1:0]                           merged_o
);

    localparam int MASK_SEGS = mask_segs(WIDTH, MASK_GRAN);

    always_comb begin
        merged_o = old_i;
        for (int s = 0; s < MASK_SEGS; s++) begin
            if (mask_i[s]) merged_o[s*MASK_GRAN +: MASK_GRAN] = new_i[s*MASK_GRAN +: MASK_GRAN];
        end
    end

endmodule

// File: rtl/sram_1r1w_mask_ext.sv
// 1R1W masked SRAM with post-reset zero clear; read latency 1 (2 with OUT_REG), no backpressure.
// ARRAY_RDW_BYPASS_EN selects write-first same-address read-during-write (default read-first).
module sram_1r1w_mask_ext
    import sram_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 512,
    parameter int MASK_GRAN = 512,
    parameter int OUT_REG   = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 init_busy,
    sram_1r1w_mask_ext_if.slave  bus
);

    localparam int                ADDR_W    = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_in_range, rd_in_range, wr_fire, rd_fire;
    logic [WIDTH-1:0]  wr_old, wr_merged, rd_raw, rd_word;
    logic              rd_vld_q;
    logic [WIDTH-1:0]  rd_dat_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        init_busy = (state_q == CLEAR);
    end

    // Out-of-range addresses only exist for non-power-of-2 depths.
    assign wr_in_range = ({1'b0, bus.W0_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.R0_addr} < DEPTH_EXT);
    assign wr_fire     = !init_busy && bus.W0_en && wr_in_range;
    assign rd_fire     = !init_busy && bus.R0_en;
    assign wr_old      = wr_in_range ? mem_q[bus.W0_addr] : '0;
    assign rd_raw      = rd_in_range ? mem_q[bus.R0_addr] : '0;

    sram_mask_merge #(
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN)
    ) u_merge (
        .old_i    (wr_old),
        .new_i    (bus.W0_data),
        .mask_i   (bus.W0_mask),
        .merged_o (wr_merged)
    );

`ifdef ARRAY_RDW_BYPASS_EN
    // On a same-address hit wr_old is the read entry, so the merged word is the write-first view.
    assign rd_word = (wr_fire && (bus.R0_addr == bus.W0_addr)) ? wr_merged : rd_raw;
`else
    assign rd_word = rd_raw;
`endif

    always_ff @(posedge clock) begin
        if (init_busy) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_fire) begin
            mem_q[bus.W0_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_fire;
            if (rd_fire) rd_dat_q <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             out_vld_q;
        logic [WIDTH-1:0] out_dat_q;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                out_vld_q <= 1'b0;
                out_dat_q <= '0;
            end else begin
                out_vld_q <= rd_vld_q;
                if (rd_vld_q) out_dat_q <= rd_dat_q;
            end
        end

        assign bus.R0_valid = out_vld_q;
        assign bus.R0_data  = out_dat_q;
    end else begin : g_no_out_reg
        assign bus.R0_valid = rd_vld_q;
        assign bus.R0_data  = rd_dat_q;
    end

endmodule

// File: tb/tb_sram_1r1w_mask_ext.sv
// Directed bench: u0 is 64x32 (byte lanes, latency 1), u1 is 6x16 (byte lanes, latency 2, non-power-of-2 depth).
module tb_sram_1r1w_mask_ext;

    logic clock;
    logic reset_n;
    logic busy0, busy1;
    int   n_checks;
    int   n_fail;

    sram_1r1w_mask_ext_if #(.DEPTH(64), .WIDTH(32), .MASK_GRAN(8)) if0 ();
    sram_1r1w_mask_ext_if #(.DEPTH(6),  .WIDTH(16), .MASK_GRAN(8)) if1 ();

    sram_1r1w_mask_ext #(.DEPTH(64), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(0)) u0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .init_busy (busy0),
        .bus       (if0)
    );

    sram_1r1w_mask_ext #(.DEPTH(6), .WIDTH(16), .MASK_GRAN(8), .OUT_REG(1)) u1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .init_busy (busy1),
        .bus       (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        if0.W0_addr = a; if0.W0_data = d; if0.W0_mask = m; if0.W0_en = 1'b1;
        tick();
        if0.W0_en = 1'b0;
    endtask

    task automatic rd0(input logic [5:0] a, input logic [31:0] exp, input string tag);
        if0.R0_addr = a; if0.R0_en = 1'b1;
        tick();
        if0.R0_en = 1'b0;
        check(tag, {if0.R0_valid, if0.R0_data}, {1'b1, exp});
    endtask

    task automatic wr1(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
        if1.W0_addr = a; if1.W0_data = d; if1.W0_mask = m; if1.W0_en = 1'b1;
        tick();
        if1.W0_en = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] a, input logic [15:0] exp, input string tag);
        if1.R0_addr = a; if1.R0_en = 1'b1;
        tick();
        if1.R0_en = 1'b0;
        check({tag, "_lat"}, {63'd0, if1.R0_valid}, 64'd0);
        tick();
        check(tag, {if1.R0_valid, if1.R0_data}, {1'b1, exp});
        tick();
        check({tag, "_hold"}, {if1.R0_valid, if1.R0_data}, {1'b0, exp});
    endtask

    // Counts cycles of init_busy from the current sample onwards, bounded.
    task automatic count_busy(output int n0, output int n1, output logic seen_vld);
        n0 = 0; n1 = 0; seen_vld = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!(busy0 || busy1)) break;
            n0 += int'(busy0);
            n1 += int'(busy1);
            seen_vld |= if0.R0_valid;
            tick();
        end
        seen_vld |= if0.R0_valid;
    endtask

    initial begin
        int          n0, n1;
        logic        seen;
        logic [31:0] rdw_exp, rdw_part_exp;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        if0.R0_addr = '0; if0.R0_en = 1'b0; if0.W0_addr = '0; if0.W0_en = 1'b0;
        if0.W0_data = '0; if0.W0_mask = '0;
        if1.R0_addr = '0; if1.R0_en = 1'b0; if1.W0_addr = '0; if1.W0_en = 1'b0;
        if1.W0_data = '0; if1.W0_mask = '0;

        repeat (3) tick();
        check("rst_busy0",  {63'd0, busy0}, 64'd1);
        check("rst_vld0",   {63'd0, if0.R0_valid}, 64'd0);
        check("rst_data0",  {32'd0, if0.R0_data}, 64'd0);
        check("rst_busy1",  {63'd0, busy1}, 64'd1);
        check("rst_vld1",   {63'd0, if1.R0_valid}, 64'd0);
        check("rst_data1",  {48'd0, if1.R0_data}, 64'd0);

        // Requests held high during the clear must be ignored.
        reset_n = 1'b1;
        if0.R0_addr = 6'd7; if0.R0_en = 1'b1;
        if0.W0_addr = 6'd7; if0.W0_data = 32'h1234_5678; if0.W0_mask = 4'hF; if0.W0_en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            seen |= if0.R0_valid;
            tick();
        end
        check("busy_mid_clear", {63'd0, busy0}, 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy(n0, n1, rdw_exp[0]);
        seen |= rdw_exp[0];
        if0.R0_en = 1'b0; if0.W0_en = 1'b0;
        check("busy_len0_restart", 64'(n0), 64'd64);
        check("busy_len1",         64'(n1), 64'd6);
        check("no_vld_during_busy", {63'd0, seen}, 64'd0);
        rd0(6'd7, 32'h0, "blocked_write");

        // Masked writes on byte lanes.
        wr0(6'd3, 32'hAABB_CCDD, 4'b1111);
        wr0(6'd3, 32'h1122_3344, 4'b0101);
        wr0(6'd3, 32'hFFFF_FFFF, 4'b0000);
        rd0(6'd3, 32'hAA22_CC44, "mask_merge");
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold0", {if0.R0_valid, if0.R0_data}, {1'b0, 32'hAA22_CC44});
        end

        // Same-address read during write.
`ifdef ARRAY_RDW_BYPASS_EN
        rdw_exp      = 32'hDEAD_BEEF;
        rdw_part_exp = 32'h0000_F00D;
`else
        rdw_exp      = 32'h0;
        rdw_part_exp = 32'h0;
`endif
        if0.W0_addr = 6'd5; if0.W0_data = 32'hDEAD_BEEF; if0.W0_mask = 4'hF; if0.W0_en = 1'b1;
        if0.R0_addr = 6'd5; if0.R0_en = 1'b1;
        tick();
        if0.W0_en = 1'b0; if0.R0_en = 1'b0;
        check("rdw_full", {if0.R0_valid, if0.R0_data}, {1'b1, rdw_exp});
        rd0(6'd5, 32'hDEAD_BEEF, "rdw_next_read");

        if0.W0_addr = 6'd6; if0.W0_data = 32'hCAFE_F00D; if0.W0_mask = 4'b0011; if0.W0_en = 1'b1;
        if0.R0_addr = 6'd6; if0.R0_en = 1'b1;
        tick();
        if0.W0_en = 1'b0; if0.R0_en = 1'b0;
        check("rdw_partial", {if0.R0_valid, if0.R0_data}, {1'b1, rdw_part_exp});
        rd0(6'd6, 32'h0000_F00D, "rdw_partial_next");

        // Different addresses in the same cycle are independent.
        if0.W0_addr = 6'd9; if0.W0_data = 32'h7777_7777; if0.W0_mask = 4'hF; if0.W0_en = 1'b1;
        if0.R0_addr = 6'd3; if0.R0_en = 1'b1;
        tick();
        if0.W0_en = 1'b0; if0.R0_en = 1'b0;
        check("indep_rd", {if0.R0_valid, if0.R0_data}, {1'b1, 32'hAA22_CC44});
        rd0(6'd9, 32'h7777_7777, "indep_wr");

        wr0(6'd10, 32'h0BAD_F00D, 4'hF);
        rd0(6'd10, 32'h0BAD_F00D, "wr_then_rd");

        // u1: latency 2, out-of-range addresses, masked lanes.
        wr1(3'd5, 16'h1234, 2'b11);
        wr1(3'd6, 16'hBEEF, 2'b11);
        wr1(3'd7, 16'hBEEF, 2'b11);
        rd1(3'd6, 16'h0000, "oor_rd6");
        rd1(3'd7, 16'h0000, "oor_rd7");
        rd1(3'd5, 16'h1234, "u1_rd5");
        wr1(3'd5, 16'hABCD, 2'b10);
        rd1(3'd5, 16'hAB34, "u1_mask");

        // Re-clear from READY wipes previously written data.
        for (int a = 0; a < 6; a++) wr1(3'(a), 16'hFFFF, 2'b11);
        rd1(3'd0, 16'hFFFF, "u1_pre_clear");
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy(n0, n1, seen);
        check("reclear_len0", 64'(n0), 64'd64);
        check("reclear_len1", 64'(n1), 64'd6);
        for (int a = 0; a < 7; a++) begin
            if1.R0_addr = 3'(a); if1.R0_en = 1'b1;
            tick();
            if (a > 0) check("u1_cleared", {if1.R0_valid, if1.R0_data}, {1'b1, 16'h0000});
        end
        if1.R0_en = 1'b0;
        tick();
        check("u1_cleared_last", {if1.R0_valid, if1.R0_data}, {1'b1, 16'h0000});
        tick();
        check("u1_stream_end", {63'd0, if1.R0_valid}, 64'd0);

        // u0 streaming: 64 back-to-back reads.
        for (int a = 0; a < 64; a++) begin
            if0.W0_addr = 6'(a); if0.W0_data = 32'(a + 1); if0.W0_mask = 4'hF; if0.W0_en = 1'b1;
            tick();
        end
        if0.W0_en = 1'b0;
        for (int a = 0; a < 64; a++) begin
            if0.R0_addr = 6'(a); if0.R0_en = 1'b1;
            tick();
            check("stream", {if0.R0_valid, if0.R0_data}, {1'b1, 32'(a + 1)});
        end
        if0.R0_en = 1'b0;
        tick();
        check("stream_end", {if0.R0_valid, if0.R0_data}, {1'b0, 32'd64});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
